// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: execute-to-writeback skid buffer behind the 16-bit ALU.
// Holds up to two ALU results in order and hands them to register-file
// writeback over valid/ready. Owns the architectural status register.
// The flags are taken from an entry only when that entry retires.
// Optional feature macro: STICKY_OVF_EN makes sreg[11] a sticky overflow bit.
//
// Occupancy FSM
//   state    | meaning
//   ST_EMPTY | no entries, out_valid=0
//   ST_ONE   | entry 0 valid (head)
//   ST_FULL  | entries 0 and 1 valid, in_ready=0
module alu_wb_buffer #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_status,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              in_setf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] sreg,
  input  logic              sov_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t state_q, state_d;

  logic              push;
  logic              pop;
  logic              commit;
  logic              load0;
  logic              load1;
  logic              shift;
  logic              in_ready_q;

  // Only status[15:12] (Z,N,V,C) is stored; the low bits never reach sreg.
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [RD_W-1:0]   rd0_q, rd1_q;
  logic              wr0_q, wr1_q;
  logic              setf0_q, setf1_q;
  logic [3:0]        flg0_q, flg1_q;

  logic [3:0]        flags_q;
  logic              sov_q;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  // A flushed head is discarded, never retired.
  assign commit    = pop & ~flush;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = data0_q;
  assign out_rd    = rd0_q;
  assign out_wr_en = wr0_q;
  assign sreg      = {flags_q, sov_q, {(DATA_W-5){1'b0}}};

  // Occupancy state and registered in_ready (no combinational path from out_ready).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next occupancy and which slot the incoming entry lands in.
  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    load1   = 1'b0;
    shift   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            load0   = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load0 = 1'b1;
          end else if (push) begin
            state_d = ST_FULL;
            load1   = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can change occupancy.
          if (pop) begin
            state_d = ST_ONE;
            shift   = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Head slot: loaded from the ALU or refilled from slot 1 on a pop; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q <= '0;
      rd0_q   <= '0;
      wr0_q   <= 1'b0;
      setf0_q <= 1'b0;
      flg0_q  <= '0;
    end else if (load0) begin
      data0_q <= in_result;
      rd0_q   <= in_rd;
      wr0_q   <= in_wr_en;
      setf0_q <= in_setf;
      flg0_q  <= in_status[DATA_W-1:DATA_W-4];
    end else if (shift) begin
      data0_q <= data1_q;
      rd0_q   <= rd1_q;
      wr0_q   <= wr1_q;
      setf0_q <= setf1_q;
      flg0_q  <= flg1_q;
    end
  end

  // Second slot: only written when the head is already occupied and not leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q <= '0;
      rd1_q   <= '0;
      wr1_q   <= 1'b0;
      setf1_q <= 1'b0;
      flg1_q  <= '0;
    end else if (load1) begin
      data1_q <= in_result;
      rd1_q   <= in_rd;
      wr1_q   <= in_wr_en;
      setf1_q <= in_setf;
      flg1_q  <= in_status[DATA_W-1:DATA_W-4];
    end
  end

  // Architectural Z,N,V,C: updated only when a flag-setting entry retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (commit && setf0_q) begin
      flags_q <= flg0_q;
    end
  end

`ifdef STICKY_OVF_EN
  // Sticky overflow: set by a retiring flag update with V=1; a same-edge clear loses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sov_q <= 1'b0;
    end else if (commit && setf0_q && flg0_q[1]) begin
      sov_q <= 1'b1;
    end else if (sov_clr) begin
      sov_q <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{in_status[DATA_W-5:0]};
`else
  assign sov_q = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{in_status[DATA_W-5:0], sov_clr};
`endif

endmodule
